// File: rtl/ibex_rf_backing_store.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_backing_store
// Description : Data-bus responder holding spilled register-file contexts.
//               Optional zeroise sweep: IBEX_RF_BACKING_STORE_ZEROIZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_backing_store #(
    parameter logic [31:0] BaseAddr    = 32'h0001_0000,
    parameter int unsigned NumContexts = 4,
    parameter int unsigned ReadLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        clear_req_i,
    output logic        clear_busy_o
);

    localparam int unsigned Depth    = NumContexts * 32;
    localparam int unsigned IdxW     = $clog2(Depth);
    localparam logic [31:0] WinBytes = 32'(NumContexts * 128);

    logic [31:0]     mem [Depth];
    logic [31:0]     offset;
    logic            addr_err;
    logic [IdxW-1:0] idx;
    logic            wr_en;
    logic            clear_we;
    logic [IdxW-1:0] clear_idx;

    // Below-window addresses wrap to a huge offset, so one compare covers both bounds.
    assign offset   = data_addr_i - BaseAddr;
    assign addr_err = (data_addr_i[1:0] != 2'b00) || (offset >= WinBytes);
    assign idx      = offset[IdxW+1:2];

`ifdef IBEX_RF_BACKING_STORE_ZEROIZE_EN
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    logic [IdxW-1:0] sweep_cnt;
    logic            busy_q;

    assign data_gnt_o = rst_ni && (state == IDLE) && data_req_i && !clear_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req_i) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_cnt == IdxW'(Depth - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clear_busy_o = busy_q;
    assign clear_we     = (state == CLEAR);
    assign clear_idx    = sweep_cnt;
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req_i;
    assign data_gnt_o       = rst_ni && data_req_i;
    assign clear_busy_o     = 1'b0;
    assign clear_we         = 1'b0;
    assign clear_idx        = '0;
`endif

    assign wr_en = data_gnt_o && data_we_i && !addr_err;

    always_ff @(posedge clk_i) begin
        if (clear_we) begin
            mem[clear_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the array at the grant edge.
    logic [ReadLatency-1:0] pipe_vld;
    logic [ReadLatency-1:0] pipe_err;
    logic [31:0]            pipe_data [ReadLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= data_gnt_o;
            pipe_err[0]  <= data_gnt_o && addr_err;
            pipe_data[0] <= (data_gnt_o && !data_we_i && !addr_err) ? mem[idx] : 32'h0;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_vld[ReadLatency-1];
    assign data_err_o    = pipe_err[ReadLatency-1];
    assign data_rdata_o  = pipe_data[ReadLatency-1];

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_backing_store.sv
`default_nettype none
// Scoreboard bench: two instances (latency 1 and 3) share stimulus; monitors check responses.
module tb_ibex_rf_backing_store;

    localparam logic [31:0] B = 32'h0001_0000;

    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b1, we = 1'b0, clr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        gnt1, rv1, er1, busy1, gnt3, rv3, er3, busy3;
    logic [31:0] rd1, rd3;

    ibex_rf_backing_store #(.BaseAddr(B), .NumContexts(4), .ReadLatency(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt1),
        .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd1), .data_err_o(er1),
        .clear_req_i(clr), .clear_busy_o(busy1));

    ibex_rf_backing_store #(.BaseAddr(B), .NumContexts(4), .ReadLatency(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt3),
        .data_rvalid_o(rv3), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_rdata_o(rd3), .data_err_o(er3),
        .clear_req_i(clr), .clear_busy_o(busy3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } rsp_t;

    rsp_t q1[$], q3[$];
    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    rsp_t m1, m3;
    always @(negedge clk) begin
        if (rv1) begin
            if (q1.size() == 0) begin
                chk("lat1_unexpected_rvalid", 32'(rv1), 32'h0);
            end else begin
                m1 = q1.pop_front();
                chk("lat1_rdata", rd1, m1.d);
                chk("lat1_err", 32'(er1), 32'(m1.e));
                chk("lat1_cycle", 32'(cyc), 32'(m1.c));
            end
        end
    end

    always @(negedge clk) begin
        if (rv3) begin
            if (q3.size() == 0) begin
                chk("lat3_unexpected_rvalid", 32'(rv3), 32'h0);
            end else begin
                m3 = q3.pop_front();
                chk("lat3_rdata", rd3, m3.d);
                chk("lat3_err", 32'(er3), 32'(m3.e));
                chk("lat3_cycle", 32'(cyc), 32'(m3.c));
            end
        end
    end

    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] erd, input logic ee,
                         input logic c = 1'b0, input logic eg = 1'b1, input logic p3 = 1'b1);
        rsp_t r;
        @(posedge clk); #1;
        req = 1'b1; we = w; be = b; addr = a; wdata = d; clr = c;
        @(negedge clk);
        chk("gnt_lat1", 32'(gnt1), 32'(eg));
        chk("gnt_lat3", 32'(gnt3), 32'(eg));
        if (eg) begin
            r.d = erd; r.e = ee;
            r.c = cyc + 1; q1.push_back(r);
            r.c = cyc + 3; if (p3) q3.push_back(r);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0; clr = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC200_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    int n1, n3;
    bit seen;

    initial begin
        // Reset state, with a request pending
        repeat (2) @(negedge clk);
        chk("rst_gnt1", 32'(gnt1), 32'h0);
        chk("rst_gnt3", 32'(gnt3), 32'h0);
        chk("rst_rvalid", {30'h0, rv1, rv3}, 32'h0);
        chk("rst_rdata1", rd1, 32'h0);
        chk("rst_err", {30'h0, er1, er3}, 32'h0);
        chk("rst_busy", {30'h0, busy1, busy3}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1; req = 1'b0;

        // Full write and read-back, top word of context 0
        issue(1'b1, 4'hF, B + 32'h7C, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h7C, 32'h0, 32'hDEADBEEF, 1'b0);
        idle();

        // Byte-enable merge, then a be=0 write is a silent no-op
        issue(1'b1, 4'hF, B + 32'h40, 32'h11223344, 32'h0, 1'b0);
        issue(1'b1, 4'b0101, B + 32'h40, 32'hAABBCCDD, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h11BB33DD, 1'b0);
        issue(1'b1, 4'h0, B + 32'h40, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h11BB33DD, 1'b0);

        // Decode errors leave the array untouched
        issue(1'b1, 4'hF, B, 32'h0BADF00D, 32'h0, 1'b0);
        issue(1'b1, 4'hF, B + 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b1, 4'hF, B - 32'h4, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b1, 4'hF, B + 32'h200, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b0, 4'h0, B + 32'h2, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 4'h0, B + 32'h200, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 4'h0, B, 32'h0, 32'h0BADF00D, 1'b0);
        issue(1'b1, 4'hF, B + 32'h1FC, 32'h5A5A5A5A, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h1FC, 32'h0, 32'h5A5A5A5A, 1'b0);
        idle();

        // Spill then reload context 2, 64 back-to-back grants
        for (int i = 0; i < 32; i++)
            issue(1'b1, 4'hF, B + 32'h100 + 32'(4 * i), pat(i), 32'h0, 1'b0);
        for (int i = 0; i < 32; i++)
            issue(1'b0, 4'h0, B + 32'h100 + 32'(4 * i), 32'h0, pat(i), 1'b0);
        idle();
        repeat (4) idle();

`ifdef IBEX_RF_BACKING_STORE_ZEROIZE_EN
        // Read outstanding across the start of a sweep; clear beats a same-cycle request
        issue(1'b0, 4'h0, B + 32'h7C, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n1 = 0; n3 = 0; seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            req = (n1 == 10); clr = (n1 == 10); we = 1'b0;
            @(negedge clk);
            if (n1 == 10 && busy1) chk("gnt_during_sweep", {30'h0, gnt1, gnt3}, 32'h0);
            if (busy3) n3++;
            if (busy1) begin n1++; seen = 1; end
            else if (seen) break;
        end
        chk("sweep_len_lat1", 32'(n1), 32'd128);
        chk("sweep_len_lat3", 32'(n3), 32'd128);
        issue(1'b0, 4'h0, B + 32'h7C, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h104, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h1FC, 32'h0, 32'h0, 1'b0);
        idle();
        repeat (4) idle();

        // Reset mid-sweep: the latency-3 response is flushed
        issue(1'b1, 4'hF, B + 32'h7C, 32'h12345678, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h7C, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0; clr = 1'b0;
        #1;
        chk("busy_at_reset", {30'h0, busy1, busy3}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rvalid_in_reset", {30'h0, rv1, rv3}, 32'h0);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        issue(1'b1, 4'hF, B + 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 4'h0, B + 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        idle();
`else
        // Without the zeroise option clear_req_i has no effect
        issue(1'b0, 4'h0, B + 32'h40, 32'h0, 32'h11BB33DD, 1'b0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("busy_tied_low", {30'h0, busy1, busy3}, 32'h0);
`endif

        repeat (6) idle();
        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q3_drained", 32'(q3.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
